// File: rtl/mux_pkg.sv
// Shared constants and index helpers for the 8-way round-robin collector.
package mux_pkg;

   localparam int N_CANAIS = 8;
   localparam int SEL_W    = 3;

   // Rotating index: (base + off) mod N_CANAIS. N_CANAIS is a power of two,
   // so the natural SEL_W-bit wrap of the sum is the modulo.
   function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                 input logic [SEL_W-1:0] off);
      return base + off;
   endfunction

   // Next pointer after serving channel idx (7 wraps to 0).
   function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
      return wrap_add(idx, 3'd1);
   endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// Purely combinational 8-way round-robin arbiter: grants the first requester
// found when searching ptr, ptr+1, ..., ptr+7 (mod 8).
module rr_arbiter8
   import mux_pkg::*;
(
   input  logic [N_CANAIS-1:0] req_i,
   input  logic [SEL_W-1:0]    ptr_i,
   output logic [SEL_W-1:0]    grant_idx_o,
   output logic                any_req_o
);

   logic [SEL_W-1:0] cand_s;
   logic             hit_s;

   // Priority search starting at ptr; the first hit locks the grant.
   always_comb begin
      grant_idx_o = {SEL_W{1'b0}};
      any_req_o   = 1'b0;
      cand_s      = {SEL_W{1'b0}};
      hit_s       = 1'b0;
      for (int i = 0; i < N_CANAIS; i++) begin
         cand_s      = wrap_add(ptr_i, SEL_W'(i));
         hit_s       = !any_req_o && req_i[cand_s];
         grant_idx_o = hit_s ? cand_s : grant_idx_o;
         any_req_o   = any_req_o | req_i[cand_s];
      end
   end

endmodule

// File: rtl/mux8way_rr.sv
// 8-to-1 valid/ready collector with round-robin arbitration and a one-entry
// registered output stage tagged with the source channel index.
module mux8way_rr
   import mux_pkg::*;
#(
   parameter int LARGURA = 4
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_CANAIS*LARGURA-1:0]   entrada,
   input  logic [N_CANAIS-1:0]           entrada_valida,
   output logic [N_CANAIS-1:0]           entrada_pronta,
   output logic [LARGURA-1:0]            saida,
   output logic [SEL_W-1:0]              sel,
   output logic                          saida_valida,
   input  logic                          saida_pronta
);

   logic [LARGURA-1:0]  saida_q, saida_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic                valida_q, valida_d;
   logic [SEL_W-1:0]    ptr_q, ptr_d;

   logic [SEL_W-1:0]    grant_s;
   logic                any_req_s;
   logic                carrega_s;
   logic                xfer_s;
   logic [LARGURA-1:0]  dado_s;

   rr_arbiter8 u_arb (
      .req_i       (entrada_valida),
      .ptr_i       (ptr_q),
      .grant_idx_o (grant_s),
      .any_req_o   (any_req_s)
   );

   // Output register can take a beat when empty or draining this cycle.
   assign carrega_s = !valida_q || saida_pronta;
   // A granted channel is valid by construction, so any request plus room means a transfer.
   assign xfer_s    = carrega_s && any_req_s;
   assign dado_s    = entrada[32'(grant_s) * LARGURA +: LARGURA];

   // One-hot ready toward the granted channel only when a transfer happens.
   always_comb begin
      entrada_pronta = {N_CANAIS{1'b0}};
      if (xfer_s) begin
         entrada_pronta[grant_s] = 1'b1;
      end else begin
         entrada_pronta = {N_CANAIS{1'b0}};
      end
   end

   // Next-state: load on transfer, clear valid on a pure drain, otherwise hold.
   always_comb begin
      saida_d  = saida_q;
      sel_d    = sel_q;
      valida_d = valida_q;
      ptr_d    = ptr_q;
      if (xfer_s) begin
         saida_d  = dado_s;
         sel_d    = grant_s;
         valida_d = 1'b1;
         ptr_d    = wrap_inc(grant_s);
      end else if (valida_q && saida_pronta) begin
         valida_d = 1'b0;
      end else begin
         valida_d = valida_q;
      end
   end

   // State registers; reset discards any held beat at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         saida_q  <= {LARGURA{1'b0}};
         sel_q    <= {SEL_W{1'b0}};
         valida_q <= 1'b0;
         ptr_q    <= {SEL_W{1'b0}};
      end else begin
         saida_q  <= saida_d;
         sel_q    <= sel_d;
         valida_q <= valida_d;
         ptr_q    <= ptr_d;
      end
   end

   assign saida        = saida_q;
   assign sel          = sel_q;
   assign saida_valida = valida_q;

endmodule

// File: tb/tb_mux8way_rr.sv
// Self-checking bench for mux8way_rr: scenario tasks with a scoreboard of
// expected {sel, data} beats popped as the output is consumed.
module tb_mux8way_rr;

   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [8*LW-1:0] entrada;
   logic [7:0]    entrada_valida;
   logic [7:0]    entrada_pronta;
   logic [LW-1:0] saida;
   logic [2:0]    sel;
   logic          saida_valida;
   logic          saida_pronta;

   int errors = 0;
   int checks = 0;
   logic [6:0] sb[$];
   logic [6:0] exp_v;

   mux8way_rr #(.LARGURA(LW)) dut (
      .clk            (clk),
      .reset          (reset),
      .entrada        (entrada),
      .entrada_valida (entrada_valida),
      .entrada_pronta (entrada_pronta),
      .saida          (saida),
      .sel            (sel),
      .saida_valida   (saida_valida),
      .saida_pronta   (saida_pronta)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      entrada_valida = 8'h00;
      entrada        = '0;
      saida_pronta   = 1'b0;
      reset          = 1'b1;
      #1;
      reset          = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; entrada = '0; entrada_valida = 8'h00; saida_pronta = 1'b0;
      #1;
      checks++;
      if ({saida_valida, sel, saida, entrada_pronta} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_init: got v=%b sel=%0d d=%h rdy=%h, required all 0", saida_valida, sel, saida, entrada_pronta);
      end
      #1 reset = 1'b0;
      entrada[0 +: LW] = 4'h3; entrada_valida = 8'h01;
      tick();
      entrada_valida = 8'h00;
      checks++;
      if (saida_valida !== 1'b1 || saida !== 4'h3) begin
         errors++;
         $display("FAIL reset_preload: got v=%b d=%h, required v=1 d=3", saida_valida, saida);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({saida_valida, sel, saida} !== 8'h00) begin
         errors++;
         $display("FAIL reset_async: got v=%b sel=%0d d=%h, required all 0 before any edge", saida_valida, sel, saida);
      end
      #1 reset = 1'b0;
      entrada[2*LW +: LW] = 4'hA; entrada_valida = 8'b0000_0100; saida_pronta = 1'b1;
      tick();
      entrada_valida = 8'h00;
      checks++;
      if (saida_valida !== 1'b1 || sel !== 3'd2 || saida !== 4'hA) begin
         errors++;
         $display("FAIL reset_first_beat: got v=%b sel=%0d d=%h, required v=1 sel=2 d=a", saida_valida, sel, saida);
      end
      tick();
      checks++;
      if (saida_valida !== 1'b0) begin
         errors++;
         $display("FAIL reset_drain: got v=%b, required 0", saida_valida);
      end
   endtask

   task automatic test_single_sweep();
      int n;
      saida_pronta = 1'b1;
      for (int k = 0; k < 8; k++) begin
         entrada = '0;
         entrada[k*LW +: LW] = LW'(k + 1);
         entrada_valida = 8'h01 << k;
         sb.push_back({3'(k), 4'(k + 1)});
         #1;
         checks++;
         if (entrada_pronta !== (8'h01 << k)) begin
            errors++;
            $display("FAIL sweep_ready: ch=%0d got %b, required %b", k, entrada_pronta, 8'h01 << k);
         end
         n = 0;
         for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 0) entrada_valida = 8'h00;
            if (saida_valida && saida_pronta) begin
               n++;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL sweep_beat: got sel=%0d d=%h, required no beat", sel, saida);
               end else begin
                  exp_v = sb.pop_front();
                  if ({sel, saida} !== exp_v) begin
                     errors++;
                     $display("FAIL sweep_beat: got sel=%0d d=%h, required sel=%0d d=%h", sel, saida, exp_v[6:4], exp_v[3:0]);
                  end
               end
            end
         end
         checks++;
         if (n != 1) begin
            errors++;
            $display("FAIL sweep_count: ch=%0d got %0d beats, required 1", k, n);
         end
      end
   endtask

   task automatic test_full_contention();
      int seq[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
      do_reset();
      for (int k = 0; k < 8; k++) entrada[k*LW +: LW] = LW'(k);
      for (int i = 0; i < 10; i++) sb.push_back({3'(seq[i]), 4'(seq[i])});
      entrada_valida = 8'hFF;
      saida_pronta   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 9) entrada_valida = 8'h00;
         checks++;
         if (!saida_valida) begin
            errors++;
            $display("FAIL contention_bubble: cycle %0d got v=0, required 1", i);
         end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL contention_beat: got sel=%0d, required no beat", sel);
         end else begin
            exp_v = sb.pop_front();
            if ({sel, saida} !== exp_v) begin
               errors++;
               $display("FAIL contention_beat: got sel=%0d d=%h, required sel=%0d d=%h", sel, saida, exp_v[6:4], exp_v[3:0]);
            end
         end
      end
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      entrada[3*LW +: LW] = 4'h5;
      entrada[4*LW +: LW] = 4'h7;
      entrada[6*LW +: LW] = 4'h9;
      entrada_valida = 8'b0000_1000;
      sb.push_back({3'd3, 4'h5}); sb.push_back({3'd4, 4'h7}); sb.push_back({3'd6, 4'h9});
      tick();
      entrada_valida = 8'b0101_0000;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (entrada_pronta !== 8'h00 || saida_valida !== 1'b1 || sel !== 3'd3 || saida !== 4'h5) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got rdy=%h v=%b sel=%0d d=%h, required rdy=00 v=1 sel=3 d=5",
                     c, entrada_pronta, saida_valida, sel, saida);
         end
         tick();
      end
      saida_pronta = 1'b1;
      #1;
      checks++;
      if (entrada_pronta !== 8'b0001_0000) begin
         errors++;
         $display("FAIL release_ready: got %b, required 00010000", entrada_pronta);
      end
      for (int c = 0; c < 4; c++) begin
         if (c == 1) entrada_valida = 8'b0100_0000;
         if (c == 2) entrada_valida = 8'h00;
         if (saida_valida && saida_pronta) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL release_beat: got sel=%0d d=%h, required no beat", sel, saida);
            end else begin
               exp_v = sb.pop_front();
               if ({sel, saida} !== exp_v) begin
                  errors++;
                  $display("FAIL release_beat: got sel=%0d d=%h, required sel=%0d d=%h", sel, saida, exp_v[6:4], exp_v[3:0]);
               end
            end
         end
         tick();
      end
   endtask

   task automatic test_ptr_wrap();
      do_reset();
      saida_pronta = 1'b1;
      entrada[7*LW +: LW] = 4'h1;
      entrada[0*LW +: LW] = 4'h2;
      entrada[6*LW +: LW] = 4'h3;
      sb.push_back({3'd7, 4'h1}); sb.push_back({3'd0, 4'h2}); sb.push_back({3'd6, 4'h3});
      entrada_valida = 8'h80;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (c == 0) begin
            entrada_valida = 8'h41;
            #1;
            checks++;
            if (entrada_pronta !== 8'h01) begin
               errors++;
               $display("FAIL wrap_ready: got %b, required 00000001", entrada_pronta);
            end
         end
         if (c == 1) entrada_valida = 8'h40;
         if (c == 2) entrada_valida = 8'h00;
         if (saida_valida && saida_pronta) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL wrap_beat: got sel=%0d d=%h, required no beat", sel, saida);
            end else begin
               exp_v = sb.pop_front();
               if ({sel, saida} !== exp_v) begin
                  errors++;
                  $display("FAIL wrap_beat: got sel=%0d d=%h, required sel=%0d d=%h", sel, saida, exp_v[6:4], exp_v[3:0]);
               end
            end
         end
      end
   endtask

   task automatic test_drain_idle();
      do_reset();
      saida_pronta = 1'b1;
      entrada[5*LW +: LW] = 4'hC;
      entrada[7*LW +: LW] = 4'hE;
      entrada[2*LW +: LW] = 4'h6;
      entrada_valida = 8'b0010_0000;
      tick();
      entrada_valida = 8'h00;
      checks++;
      if (saida_valida !== 1'b1 || sel !== 3'd5 || saida !== 4'hC) begin
         errors++;
         $display("FAIL drain_load: got v=%b sel=%0d d=%h, required v=1 sel=5 d=c", saida_valida, sel, saida);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (saida_valida !== 1'b0 || sel !== 3'd5 || saida !== 4'hC) begin
            errors++;
            $display("FAIL drain_hold: cycle %0d got v=%b sel=%0d d=%h, required v=0 sel=5 d=c", c, saida_valida, sel, saida);
         end
      end
      entrada_valida = 8'b1000_0100;
      sb.push_back({3'd7, 4'hE}); sb.push_back({3'd2, 4'h6});
      #1;
      checks++;
      if (entrada_pronta !== 8'b1000_0000) begin
         errors++;
         $display("FAIL idle_ptr: got %b, required 10000000", entrada_pronta);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         if (c == 0) entrada_valida = 8'b0000_0100;
         if (c == 1) entrada_valida = 8'h00;
         if (saida_valida && saida_pronta) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL idle_beat: got sel=%0d d=%h, required no beat", sel, saida);
            end else begin
               exp_v = sb.pop_front();
               if ({sel, saida} !== exp_v) begin
                  errors++;
                  $display("FAIL idle_beat: got sel=%0d d=%h, required sel=%0d d=%h", sel, saida, exp_v[6:4], exp_v[3:0]);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_sweep();
      test_full_contention();
      test_backpressure();
      test_ptr_wrap();
      test_drain_idle();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %0d beats never seen, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
